// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Moore-style controller for a multi-cycle MIPS datapath (PC, IR, register
// file, ALU, data memory port, clocked sign/zero extender). It decodes the IR
// opcode/funct fields, steps through one state per datapath phase and drives
// every enable and select. It also owns the memory request/ready handshake.
//
// The extender is registered. It samples the immediate while the FSM is in
// DECODE, so ext_zero is driven from the opcode in every state. States from
// MEMADR/BEQ_TGT/IMM_EX onward consume the extended value.
//
// Optional feature (compile-time macro CTRL_PERF_CNT_EN):
//   defined   : instr_count counts retired instructions. It wraps at 2^32 and
//               is cleared by rst.
//   undefined : instr_count is tied to zero and no counter logic exists.
//
// Parameters:
//   RESET_STATE  state encoding loaded on reset (FETCH = 4'd0)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   opcode[5:0]  in   IR[31:26]
//   funct[5:0]   in   IR[5:0]
//   zero         in   ALU zero flag (current cycle)
//   mem_ready    in   memory completes the current request this cycle
//   mem_req      out  memory request
//   mem_we       out  memory write (1) / read (0), valid with mem_req
//   iord         out  memory address select: 0 = PC, 1 = ALUOut
//   ir_we        out  load instruction register
//   pc_we        out  load PC
//   pc_src[1:0]  out  PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   alu_src_a    out  ALU A: 0 = PC, 1 = reg A
//   alu_src_b    out  ALU B: 00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
//   alu_ctrl[3:0]out  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
//   ext_zero     out  extender mode: 1 = zero-extend, 0 = sign-extend
//   reg_we       out  register-file write
//   reg_dst      out  write destination: 1 = rd, 0 = rt
//   mem_to_reg   out  write-back source: 1 = MDR, 0 = ALUOut
//   illegal      out  sticky unsupported-instruction flag
//   state[3:0]   out  current state (debug)
//   instr_count  out  retired-instruction count (0 unless CTRL_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_ctrl,
   output logic        ext_zero,
   output logic        reg_we,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic [3:0]  state,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BEQ_TGT  = 4'd8,
      S_BEQ_CMP  = 4'd9,
      S_IMM_EX   = 4'd10,
      S_IMM_WB   = 4'd11,
      S_JUMP     = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   state_t     state_q;
   state_t     state_d;
   logic       illegal_q;
   logic       illegal_d;

   logic [3:0] rtype_alu_s;
   logic       funct_ok_s;

   // Strobes before reset gating; they must never fire during the rst cycle.
   logic       mem_req_s;
   logic       mem_we_s;
   logic       ir_we_s;
   logic       pc_we_s;
   logic       reg_we_s;

   // R-type funct decode: ALU operation and legality.
   always_comb begin
      rtype_alu_s = 4'b0000;
      funct_ok_s  = 1'b1;
      case (funct)
         FN_ADD:  rtype_alu_s = ALU_ADD;
         FN_SUB:  rtype_alu_s = ALU_SUB;
         FN_AND:  rtype_alu_s = ALU_AND;
         FN_OR:   rtype_alu_s = ALU_OR;
         FN_SLT:  rtype_alu_s = ALU_SLT;
         default: begin
            rtype_alu_s = 4'b0000;
            funct_ok_s  = 1'b0;
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
            else           state_d = S_FETCH;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:       state_d = S_RTYPE_EX;
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_BEQ:         state_d = S_BEQ_TGT;
               OP_ADDI, OP_ORI: state_d = S_IMM_EX;
               OP_J:           state_d = S_JUMP;
               default:        state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW) state_d = S_MEMRD;
            else                 state_d = S_MEMWR;
         end
         S_MEMRD: begin
            if (mem_ready) state_d = S_MEMWB;
            else           state_d = S_MEMRD;
         end
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWR: begin
            if (mem_ready) state_d = S_FETCH;
            else           state_d = S_MEMWR;
         end
         S_RTYPE_EX: begin
            if (funct_ok_s) state_d = S_RTYPE_WB;
            else            state_d = S_TRAP;
         end
         S_RTYPE_WB: state_d = S_FETCH;
         S_BEQ_TGT:  state_d = S_BEQ_CMP;
         S_BEQ_CMP:  state_d = S_FETCH;
         S_IMM_EX:   state_d = S_IMM_WB;
         S_IMM_WB:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // Sticky illegal flag: set on entry to TRAP, only rst clears it.
   always_comb begin
      if (state_d == S_TRAP) illegal_d = 1'b1;
      else                   illegal_d = illegal_q;
   end

   // Moore output decode; mem_ready and zero only qualify the FETCH/BEQ_CMP writes.
   always_comb begin
      mem_req_s  = 1'b0;
      mem_we_s   = 1'b0;
      iord       = 1'b0;
      ir_we_s    = 1'b0;
      pc_we_s    = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 4'b0000;
      reg_we_s   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_s = 1'b1;
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_ADD;
            ir_we_s   = mem_ready;
            pc_we_s   = mem_ready;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = ALU_ADD;
         end
         S_MEMRD: begin
            mem_req_s = 1'b1;
            iord      = 1'b1;
         end
         S_MEMWB: begin
            reg_we_s   = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_req_s = 1'b1;
            mem_we_s  = 1'b1;
            iord      = 1'b1;
         end
         S_RTYPE_EX: begin
            alu_src_a = 1'b1;
            alu_ctrl  = rtype_alu_s;
         end
         S_RTYPE_WB: begin
            reg_we_s = 1'b1;
            reg_dst  = 1'b1;
         end
         S_BEQ_TGT: begin
            // PC already holds PC+4 from FETCH; target = PC + (imm << 2).
            alu_src_b = 2'b11;
            alu_ctrl  = ALU_ADD;
         end
         S_BEQ_CMP: begin
            alu_src_a = 1'b1;
            alu_ctrl  = ALU_SUB;
            pc_src    = 2'b01;
            pc_we_s   = zero;
         end
         S_IMM_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (opcode == OP_ORI) alu_ctrl = ALU_OR;
            else                  alu_ctrl = ALU_ADD;
         end
         S_IMM_WB: begin
            reg_we_s = 1'b1;
         end
         S_JUMP: begin
            pc_src  = 2'b10;
            pc_we_s = 1'b1;
         end
         default: begin
            mem_req_s = 1'b0;
         end
      endcase
   end

   // Strobe gating: nothing fires in a reset cycle, so an in-flight write is dropped.
   always_comb begin
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         reg_we  = 1'b0;
      end else begin
         mem_req = mem_req_s;
         mem_we  = mem_we_s;
         ir_we   = ir_we_s;
         pc_we   = pc_we_s;
         reg_we  = reg_we_s;
      end
   end

   assign ext_zero = (opcode == OP_ORI);
   assign illegal  = illegal_q;
   assign state    = state_q;

   // State and sticky-flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= state_t'(RESET_STATE);
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] instr_count_q;
   logic [31:0] instr_count_d;
   logic        retire_s;

   // An instruction retires when its last state hands control back to FETCH.
   always_comb begin
      retire_s = 1'b0;
      case (state_q)
         S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BEQ_CMP, S_IMM_WB, S_JUMP:
            retire_s = (state_d == S_FETCH);
         default:
            retire_s = 1'b0;
      endcase
      if (retire_s) instr_count_d = instr_count_q + 32'd1;
      else          instr_count_d = instr_count_q;
   end

   // Retired-instruction counter register.
   always_ff @(posedge clk) begin
      if (rst) instr_count_q <= 32'd0;
      else     instr_count_q <= instr_count_d;
   end

   assign instr_count = instr_count_q;
`else
   assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mips_multicycle_ctrl. Per-cycle vectors hold inputs and
// hand-derived expected outputs. Expectations are queued when a vector is
// driven and popped and compared once the outputs have settled after the
// falling edge. A few hand-written sequences cover TRAP stickiness and
// recovery.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   localparam logic [3:0] A_ADD = 4'b0010;
   localparam logic [3:0] A_SUB = 4'b0110;
   localparam logic [3:0] A_AND = 4'b0000;
   localparam logic [3:0] A_OR  = 4'b0001;
   localparam logic [3:0] A_SLT = 4'b0111;

   typedef struct packed {
      logic       rst;
      logic [5:0] opcode;
      logic [5:0] funct;
      logic       zero;
      logic       rdy;
   } in_t;

   typedef struct packed {
      logic [3:0]  st;
      logic        req;
      logic        we;
      logic        io;
      logic        irw;
      logic        pcw;
      logic [1:0]  ps;
      logic        sa;
      logic [1:0]  sb;
      logic [3:0]  alu;
      logic        ez;
      logic        rw;
      logic        rd;
      logic        m2r;
      logic        ill;
      logic [31:0] cnt;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_we, iord, ir_we, pc_we;
   logic [1:0]  pc_src;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [3:0]  alu_ctrl;
   logic        ext_zero, reg_we, reg_dst, mem_to_reg, illegal;
   logic [3:0]  state;
   logic [31:0] instr_count;

   int   n_tests = 0;
   int   n_fail  = 0;
   out_t exp_q[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .ext_zero(ext_zero),
      .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .illegal(illegal), .state(state), .instr_count(instr_count)
   );

   // Build one vector; cnt is the retired count expected when the counter exists.
   function automatic vec_t mk(
      input logic r, input logic [5:0] op, input logic [5:0] fn,
      input logic z, input logic rdy, input logic [3:0] st,
      input logic req, input logic we, input logic io, input logic irw,
      input logic pcw, input logic [1:0] ps, input logic sa,
      input logic [1:0] sb, input logic [3:0] alu, input logic ez,
      input logic rw, input logic rd, input logic m2r, input logic ill,
      input int unsigned cnt);
      vec_t v;
      v.i = '{rst: r, opcode: op, funct: fn, zero: z, rdy: rdy};
      v.o.st = st;  v.o.req = req; v.o.we = we;  v.o.io = io;
      v.o.irw = irw; v.o.pcw = pcw; v.o.ps = ps; v.o.sa = sa;
      v.o.sb = sb;  v.o.alu = alu; v.o.ez = ez;  v.o.rw = rw;
      v.o.rd = rd;  v.o.m2r = m2r; v.o.ill = ill;
`ifdef CTRL_PERF_CNT_EN
      v.o.cnt = 32'(cnt);
`else
      v.o.cnt = 32'd0;
`endif
      return v;
   endfunction

   // Drive one cycle of inputs, queue its expectation and check after settling.
   task automatic step(input vec_t v, input string tag, input int idx);
      out_t e;
      out_t a;
      @(negedge clk);
      rst       = v.i.rst;
      opcode    = v.i.opcode;
      funct     = v.i.funct;
      zero      = v.i.zero;
      mem_ready = v.i.rdy;
      exp_q.push_back(v.o);
      #1;
      a = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
           alu_src_b, alu_ctrl, ext_zero, reg_we, reg_dst, mem_to_reg,
           illegal, instr_count};
      e = exp_q.pop_front();
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s[%0d]: actual st=%0d req=%b we=%b io=%b irw=%b pcw=%b ps=%b sa=%b sb=%b alu=%b ez=%b rw=%b rd=%b m2r=%b ill=%b cnt=%0d | required st=%0d req=%b we=%b io=%b irw=%b pcw=%b ps=%b sa=%b sb=%b alu=%b ez=%b rw=%b rd=%b m2r=%b ill=%b cnt=%0d",
            tag, idx, a.st, a.req, a.we, a.io, a.irw, a.pcw, a.ps, a.sa, a.sb,
            a.alu, a.ez, a.rw, a.rd, a.m2r, a.ill, a.cnt,
            e.st, e.req, e.we, e.io, e.irw, e.pcw, e.ps, e.sa, e.sb,
            e.alu, e.ez, e.rw, e.rd, e.m2r, e.ill, e.cnt);
      end
   endtask

   initial begin
      logic [5:0] fn_tab  [0:4];
      logic [3:0] alu_tab [0:4];
      fn_tab[0] = 6'h20; alu_tab[0] = A_ADD;
      fn_tab[1] = 6'h22; alu_tab[1] = A_SUB;
      fn_tab[2] = 6'h24; alu_tab[2] = A_AND;
      fn_tab[3] = 6'h25; alu_tab[3] = A_OR;
      fn_tab[4] = 6'h2A; alu_tab[4] = A_SLT;

      // ---- vector table: r op fn z rdy | st req we io irw pcw ps sa sb alu ez rw rd m2r ill cnt
      // reset held two cycles (ready high in the second: strobes must stay low)
      vecs.push_back(mk(1,6'h00,6'h00,0,0, 4'd0, 0,0,0,0,0,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 0));
      vecs.push_back(mk(1,6'h00,6'h00,0,1, 4'd0, 0,0,0,0,0,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 0));
      // lw, zero-wait memory: 0,1,2,3,4
      vecs.push_back(mk(0,6'h23,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 0));
      vecs.push_back(mk(0,6'h23,6'h00,0,1, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 0));
      vecs.push_back(mk(0,6'h23,6'h00,0,0, 4'd2, 0,0,0,0,0,2'b00,1,2'b10,A_ADD, 0,0,0,0,0, 0));
      vecs.push_back(mk(0,6'h23,6'h00,0,1, 4'd3, 1,0,1,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 0));
      vecs.push_back(mk(0,6'h23,6'h00,0,0, 4'd4, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,1,0,1,0, 0));
      // sw: one FETCH wait, then three MEMWR wait cycles
      vecs.push_back(mk(0,6'h2B,6'h00,0,0, 4'd0, 1,0,0,0,0,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 1));
      vecs.push_back(mk(0,6'h2B,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 1));
      vecs.push_back(mk(0,6'h2B,6'h00,0,0, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 1));
      vecs.push_back(mk(0,6'h2B,6'h00,0,0, 4'd2, 0,0,0,0,0,2'b00,1,2'b10,A_ADD, 0,0,0,0,0, 1));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0,6'h2B,6'h00,0,0, 4'd5, 1,1,1,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 1));
      vecs.push_back(mk(0,6'h2B,6'h00,0,1, 4'd5, 1,1,1,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 1));
      // beq taken (zero = 1)
      vecs.push_back(mk(0,6'h04,6'h00,1,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 2));
      vecs.push_back(mk(0,6'h04,6'h00,1,0, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 2));
      vecs.push_back(mk(0,6'h04,6'h00,1,0, 4'd8, 0,0,0,0,0,2'b00,0,2'b11,A_ADD, 0,0,0,0,0, 2));
      vecs.push_back(mk(0,6'h04,6'h00,1,0, 4'd9, 0,0,0,0,1,2'b01,1,2'b00,A_SUB, 0,0,0,0,0, 2));
      // beq not taken (zero = 0)
      vecs.push_back(mk(0,6'h04,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 3));
      vecs.push_back(mk(0,6'h04,6'h00,0,1, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 3));
      vecs.push_back(mk(0,6'h04,6'h00,0,1, 4'd8, 0,0,0,0,0,2'b00,0,2'b11,A_ADD, 0,0,0,0,0, 3));
      vecs.push_back(mk(0,6'h04,6'h00,0,1, 4'd9, 0,0,0,0,0,2'b01,1,2'b00,A_SUB, 0,0,0,0,0, 3));
      // ori: zero-extend, OR
      vecs.push_back(mk(0,6'h0D,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 1,0,0,0,0, 4));
      vecs.push_back(mk(0,6'h0D,6'h00,0,0, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 1,0,0,0,0, 4));
      vecs.push_back(mk(0,6'h0D,6'h00,0,0, 4'd10,0,0,0,0,0,2'b00,1,2'b10,A_OR,  1,0,0,0,0, 4));
      vecs.push_back(mk(0,6'h0D,6'h00,0,0, 4'd11,0,0,0,0,0,2'b00,0,2'b00,4'b0000, 1,1,0,0,0, 4));
      // addi: sign-extend, ADD
      vecs.push_back(mk(0,6'h08,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 5));
      vecs.push_back(mk(0,6'h08,6'h00,0,0, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 5));
      vecs.push_back(mk(0,6'h08,6'h00,0,0, 4'd10,0,0,0,0,0,2'b00,1,2'b10,A_ADD, 0,0,0,0,0, 5));
      vecs.push_back(mk(0,6'h08,6'h00,0,0, 4'd11,0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,1,0,0,0, 5));
      // R-type: each supported funct
      for (int k = 0; k < 5; k++) begin
         vecs.push_back(mk(0,6'h00,fn_tab[k],0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 6+k));
         vecs.push_back(mk(0,6'h00,fn_tab[k],0,1, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 6+k));
         vecs.push_back(mk(0,6'h00,fn_tab[k],0,1, 4'd6, 0,0,0,0,0,2'b00,1,2'b00,alu_tab[k], 0,0,0,0,0, 6+k));
         vecs.push_back(mk(0,6'h00,fn_tab[k],0,1, 4'd7, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,1,1,0,0, 6+k));
      end
      // j
      vecs.push_back(mk(0,6'h02,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 11));
      vecs.push_back(mk(0,6'h02,6'h00,0,0, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 11));
      vecs.push_back(mk(0,6'h02,6'h00,0,0, 4'd12,0,0,0,0,1,2'b10,0,2'b00,4'b0000, 0,0,0,0,0, 11));
      // sw abandoned by reset while waiting in MEMWR
      vecs.push_back(mk(0,6'h2B,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 12));
      vecs.push_back(mk(0,6'h2B,6'h00,0,0, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 12));
      vecs.push_back(mk(0,6'h2B,6'h00,0,0, 4'd2, 0,0,0,0,0,2'b00,1,2'b10,A_ADD, 0,0,0,0,0, 12));
      vecs.push_back(mk(0,6'h2B,6'h00,0,0, 4'd5, 1,1,1,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 12));
      vecs.push_back(mk(1,6'h2B,6'h00,0,1, 4'd5, 0,0,1,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 12));
      vecs.push_back(mk(0,6'h2B,6'h00,0,0, 4'd0, 1,0,0,0,0,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 0));

      // ---- initial reset, then the table
      rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      for (int n = 0; n < vecs.size(); n++) step(vecs[n], "vec", n);

      // ---- illegal opcode 3F: TRAP is sticky, ignores ready/zero
      step(mk(0,6'h3F,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 0), "trap_op", 0);
      step(mk(0,6'h3F,6'h00,0,1, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 0), "trap_op", 1);
      for (int k = 0; k < 10; k++)
         step(mk(0,6'h3F,6'h00,1,1, 4'd13,0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,1, 0), "trap_op_hold", k);
      step(mk(1,6'h00,6'h00,0,1, 4'd13,0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,1, 0), "trap_op_rst", 0);
      step(mk(0,6'h00,6'h03,0,0, 4'd0, 1,0,0,0,0,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 0), "trap_op_rec", 0);

      // ---- R-type with unsupported funct 0x03
      step(mk(0,6'h00,6'h03,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 0), "trap_fn", 0);
      step(mk(0,6'h00,6'h03,0,0, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 0), "trap_fn", 1);
      step(mk(0,6'h00,6'h03,0,0, 4'd6, 0,0,0,0,0,2'b00,1,2'b00,4'b0000, 0,0,0,0,0, 0), "trap_fn", 2);
      for (int k = 0; k < 4; k++)
         step(mk(0,6'h00,6'h03,0,1, 4'd13,0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,1, 0), "trap_fn_hold", k);
      step(mk(1,6'h00,6'h00,0,0, 4'd13,0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,1, 0), "trap_fn_rst", 0);
      step(mk(0,6'h23,6'h00,0,1, 4'd0, 1,0,0,1,1,2'b00,0,2'b01,A_ADD, 0,0,0,0,0, 0), "trap_fn_rec", 0);
      step(mk(0,6'h23,6'h00,0,0, 4'd1, 0,0,0,0,0,2'b00,0,2'b00,4'b0000, 0,0,0,0,0, 0), "trap_fn_rec", 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style FSM controller that sequences the multi-cycle MIPS datapath: PC, instruction register, register file, ALU, data memory port and the clocked sign/zero extender.
- Sits beside the datapath. Decodes IR opcode/funct and drives all enables and selects.
- Accounts for the extender's one-cycle registered latency: the immediate is captured in DECODE and consumed from the following state on.
- Owns the memory request/ready handshake.

Parameters:
- RESET_STATE, 4'd0, state encoding loaded on reset (FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, current cycle.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write (1) / read (0); valid with mem_req.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- ext_zero  out  1  extender mode: 1 = zero-extend, 0 = sign-extend.
- reg_we  out  1  register-file write.
- reg_dst  out  1  destination: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- illegal  out  1  sticky unsupported-instruction flag.
- state  out  4  current state, for debug.
- instr_count  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BEQ_TGT 8, BEQ_CMP 9, IMM_EX 10, IMM_WB 11, JUMP 12, TRAP 13.
- Unused encodings go to FETCH.
- Reset: state = FETCH, illegal = 0, instr_count = 0. All strobes (mem_req, ir_we, pc_we, reg_we, mem_we) are low during the rst cycle.
- Outputs are decoded combinationally from state; the stated exceptions are conditioned on mem_ready or zero.
- Any output not listed for a state is 0.
- ext_zero = (opcode == 6'h0D) in every state, so it is valid in DECODE when the extender samples.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_ctrl = add, pc_src = 00.
  - ir_we = pc_we = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: one cycle; the extender captures the immediate. Next state by opcode:
  - 00 → RTYPE_EX
  - 23 or 2B → MEMADR
  - 04 → BEQ_TGT
  - 08 or 0D → IMM_EX
  - 02 → JUMP
  - anything else → TRAP
- MEMADR: A = reg A, B = ext imm, add. Next state MEMRD if opcode = 23, else MEMWR.
- MEMRD:
  - mem_req = 1, iord = 1, mem_we = 0.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_we = 1, reg_dst = 0, mem_to_reg = 1. Next state FETCH.
- MEMWR:
  - mem_req = 1, iord = 1, mem_we = 1.
  - Holds until mem_ready, then goes to FETCH.
- RTYPE_EX: A = reg A, B = reg B. alu_ctrl decoded from funct:
  - 20 → add, 22 → sub, 24 → and, 25 → or, 2A → slt.
  - Any other funct → next state TRAP. Otherwise next state RTYPE_WB.
- RTYPE_WB: reg_we = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
- BEQ_TGT: A = PC (already PC+4), B = ext imm<<2, add; the datapath latches ALUOut. Next state BEQ_CMP.
- BEQ_CMP: A = reg A, B = reg B, sub, pc_src = 01, pc_we = zero. Next state FETCH.
- IMM_EX: A = reg A, B = ext imm, alu_ctrl = add (opcode 08) or or (opcode 0D). Next state IMM_WB.
- IMM_WB: reg_we = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH.
- JUMP: pc_src = 10, pc_we = 1. Next state FETCH.
- TRAP: illegal = 1; all strobes 0. Remains in TRAP until rst.
- Memory handshake:
  - While mem_req = 1, mem_req, iord and mem_we are held stable until a cycle in which mem_ready = 1.
  - Zero-wait completion (ready in the first request cycle) is legal.
  - mem_ready is ignored while mem_req = 0.
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, beq 4, addi/ori 4, j 3. Each wait cycle adds 1.
- Reset mid-instruction: the next edge forces FETCH and no pending strobe fires after that edge. A write in progress in MEMWR is abandoned.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined: instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTYPE_WB, BEQ_CMP, IMM_WB or JUMP. Wraps at 2^32. Cleared by rst. Not incremented in TRAP.
- Undefined: instr_count is tied to 0 and no counter logic is generated.

Test Plan:
- rst held 2 cycles → state = 0, illegal = 0, all strobes 0. Release → mem_req = 1, iord = 0 on the next cycle.
- lw (opcode 23), mem_ready high every request → state sequence 0,1,2,3,4,0. reg_we with mem_to_reg = 1 in cycle 5. instr_count +1.
- sw with mem_ready delayed 3 cycles in MEMWR → mem_req/mem_we/iord held constant for 4 cycles. No extra pc_we.
- beq, zero = 1 then zero = 0 → pc_we = 1 with pc_src = 01 in BEQ_CMP only when zero = 1.
- ori (0D) → ext_zero = 1 in DECODE, IMM_EX alu_ctrl = 0001. addi (08) → ext_zero = 0, alu_ctrl = 0010.
- opcode 3F, or R-type funct 0x03 → TRAP, illegal = 1 sticky for 10 cycles. rst clears it and returns to FETCH.
